// File: rtl/hdd_pkg.sv
// Shared widths, descriptor layout and TS classification for host_descriptor_dispatch.
// Pure definitions: no latency, no backpressure.
// Descriptor packs as {bufid, pkt_type, ts_addr}, bufid in the MSBs.
package hdd_pkg;
    localparam int PORT_NUM = 4;
    localparam int BUFID_W  = 9;
    localparam int TYPE_W   = 3;
    localparam int TSADDR_W = 5;
    localparam int INPORT_W = 4;
    localparam int DESC_W   = BUFID_W + TYPE_W + TSADDR_W;

    typedef struct packed {
        logic [BUFID_W-1:0]  bufid;
        logic [TYPE_W-1:0]   pkt_type;
        logic [TSADDR_W-1:0] ts_addr;
    } desc_t;

    function automatic logic is_ts(input logic [TYPE_W-1:0] pkt_type,
                                   input logic [TYPE_W-1:0] ts_type_max);
        return pkt_type <= ts_type_max;
    endfunction
endpackage

// File: rtl/hdd_desc_fifo.sv
// Single-clock register FIFO holding one port's descriptors; head is always visible on ov_dout.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; push and pop may coincide.
module hdd_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             iv_din,
    output logic [W-1:0]             ov_dout,
    output logic [$clog2(DEPTH):0]   ov_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iv_din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ov_dout  = r_mem[r_rd_ptr];
    assign ov_count = r_count;
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
endmodule

// File: rtl/host_descriptor_dispatch.sv
// Merges four per-port descriptor FIFOs into one round-robin stream; HDD_TS_PRIORITY_EN adds TS-first arbitration.
// Latency: write at edge T is granted in cycle T+1 and appears on o_data_wr in cycle T+2.
// Backpressure: o_ready_pN low when FIFO N is full; writes while not ready are dropped and flagged; no downstream stall.
module host_descriptor_dispatch
    import hdd_pkg::*;
#(
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [TYPE_W-1:0] TS_TYPE_MAX = 3'd2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dispatch_en,
    input  logic [BUFID_W-1:0]  iv_bufid_p0,
    input  logic [BUFID_W-1:0]  iv_bufid_p1,
    input  logic [BUFID_W-1:0]  iv_bufid_p2,
    input  logic [BUFID_W-1:0]  iv_bufid_p3,
    input  logic [TYPE_W-1:0]   iv_pkt_type_p0,
    input  logic [TYPE_W-1:0]   iv_pkt_type_p1,
    input  logic [TYPE_W-1:0]   iv_pkt_type_p2,
    input  logic [TYPE_W-1:0]   iv_pkt_type_p3,
    input  logic [TSADDR_W-1:0] iv_ts_submit_addr_p0,
    input  logic [TSADDR_W-1:0] iv_ts_submit_addr_p1,
    input  logic [TSADDR_W-1:0] iv_ts_submit_addr_p2,
    input  logic [TSADDR_W-1:0] iv_ts_submit_addr_p3,
    input  logic                i_descriptor_wr_p0,
    input  logic                i_descriptor_wr_p1,
    input  logic                i_descriptor_wr_p2,
    input  logic                i_descriptor_wr_p3,
    output logic                o_ready_p0,
    output logic                o_ready_p1,
    output logic                o_ready_p2,
    output logic                o_ready_p3,
    output logic [BUFID_W-1:0]  ov_bufid,
    output logic [TYPE_W-1:0]   ov_pkt_type,
    output logic [INPORT_W-1:0] ov_pkt_inport,
    output logic [TSADDR_W-1:0] ov_ts_submit_addr,
    output logic                o_data_wr,
    output logic [PORT_NUM-1:0] ov_discard_mask,
    output logic [15:0]         ov_dispatch_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PORT_NUM-1:0] w_wr, w_ready, w_full, w_empty, w_pop, w_req, w_arb_req;
    desc_t               w_din   [PORT_NUM];
    desc_t               w_head  [PORT_NUM];
    logic [CNT_W-1:0]    w_count [PORT_NUM];
    desc_t               w_sel;
    logic                w_gnt_vld;
    logic [1:0]          w_gnt_idx;
    logic [1:0]          w_idx;

    logic [1:0]          r_rr_ptr;
    logic                r_data_wr;
    desc_t               r_desc;
    logic [1:0]          r_inport;
    logic [PORT_NUM-1:0] r_discard;
    logic [15:0]         r_cnt;

    assign w_wr   = {i_descriptor_wr_p3, i_descriptor_wr_p2, i_descriptor_wr_p1, i_descriptor_wr_p0};
    assign w_din[0] = '{bufid: iv_bufid_p0, pkt_type: iv_pkt_type_p0, ts_addr: iv_ts_submit_addr_p0};
    assign w_din[1] = '{bufid: iv_bufid_p1, pkt_type: iv_pkt_type_p1, ts_addr: iv_ts_submit_addr_p1};
    assign w_din[2] = '{bufid: iv_bufid_p2, pkt_type: iv_pkt_type_p2, ts_addr: iv_ts_submit_addr_p2};
    assign w_din[3] = '{bufid: iv_bufid_p3, pkt_type: iv_pkt_type_p3, ts_addr: iv_ts_submit_addr_p3};
    assign {o_ready_p3, o_ready_p2, o_ready_p1, o_ready_p0} = w_ready;

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_port
        hdd_desc_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DESC_W)
        ) u_fifo (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_push   (w_wr[g] & w_ready[g]),
            .i_pop    (w_pop[g]),
            .iv_din   (w_din[g]),
            .ov_dout  (w_head[g]),
            .ov_count (w_count[g]),
            .o_full   (w_full[g]),
            .o_empty  (w_empty[g])
        );
        // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
        assign w_ready[g] = (w_count[g] < CNT_W'(FIFO_DEPTH));
        assign w_req[g]   = ~w_empty[g] & i_dispatch_en;
        assign w_pop[g]   = w_gnt_vld & (w_gnt_idx == 2'(g));
    end

`ifdef HDD_TS_PRIORITY_EN
    logic [PORT_NUM-1:0] w_hp;
    for (genvar h = 0; h < PORT_NUM; h++) begin : g_hp
        assign w_hp[h] = w_req[h] & is_ts(w_head[h].pkt_type, TS_TYPE_MAX);
    end
    assign w_arb_req = (|w_hp) ? w_hp : w_req;
`else
    assign w_arb_req = w_req;
`endif

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 2'd0;
        w_idx     = 2'd0;
        for (int j = 0; j < PORT_NUM; j++) begin
            w_idx = r_rr_ptr + 2'(j);
            if (!w_gnt_vld && w_arb_req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign w_sel = w_head[w_gnt_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr  <= 2'd0;
            r_data_wr <= 1'b0;
            r_desc    <= '0;
            r_inport  <= 2'd0;
            r_discard <= '0;
            r_cnt     <= 16'd0;
        end else begin
            r_data_wr <= w_gnt_vld;
            r_discard <= w_wr & w_full;
            if (w_gnt_vld) begin
                r_desc   <= w_sel;
                r_inport <= w_gnt_idx;
                r_rr_ptr <= w_gnt_idx + 2'd1;
                r_cnt    <= r_cnt + 16'd1;
            end
        end
    end

    assign o_data_wr         = r_data_wr;
    assign ov_bufid          = r_desc.bufid;
    assign ov_pkt_type       = r_desc.pkt_type;
    assign ov_ts_submit_addr = r_desc.ts_addr;
    assign ov_pkt_inport     = {{(INPORT_W-2){1'b0}}, r_inport};
    assign ov_discard_mask   = r_discard;
    assign ov_dispatch_cnt   = r_cnt;
endmodule

// File: tb/tb_host_descriptor_dispatch.sv
// Scoreboard bench for host_descriptor_dispatch: directed stimulus queues expected descriptors, a monitor checks outputs.
module tb_host_descriptor_dispatch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [8:0]  bufid [4];
    logic [2:0]  typ   [4];
    logic [4:0]  addr  [4];
    logic [3:0]  wr;
    logic [3:0]  rdy;
    logic [8:0]  o_bufid;
    logic [2:0]  o_type;
    logic [3:0]  o_inport;
    logic [4:0]  o_addr;
    logic        o_wr;
    logic [3:0]  o_disc;
    logic [15:0] o_cnt;

    typedef logic [20:0] exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [15:0] exp_cnt;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    host_descriptor_dispatch #(.FIFO_DEPTH(4), .TS_TYPE_MAX(3'd2)) dut (
        .i_clk(clk), .i_rst(rst), .i_dispatch_en(en),
        .iv_bufid_p0(bufid[0]), .iv_bufid_p1(bufid[1]), .iv_bufid_p2(bufid[2]), .iv_bufid_p3(bufid[3]),
        .iv_pkt_type_p0(typ[0]), .iv_pkt_type_p1(typ[1]), .iv_pkt_type_p2(typ[2]), .iv_pkt_type_p3(typ[3]),
        .iv_ts_submit_addr_p0(addr[0]), .iv_ts_submit_addr_p1(addr[1]),
        .iv_ts_submit_addr_p2(addr[2]), .iv_ts_submit_addr_p3(addr[3]),
        .i_descriptor_wr_p0(wr[0]), .i_descriptor_wr_p1(wr[1]),
        .i_descriptor_wr_p2(wr[2]), .i_descriptor_wr_p3(wr[3]),
        .o_ready_p0(rdy[0]), .o_ready_p1(rdy[1]), .o_ready_p2(rdy[2]), .o_ready_p3(rdy[3]),
        .ov_bufid(o_bufid), .ov_pkt_type(o_type), .ov_pkt_inport(o_inport),
        .ov_ts_submit_addr(o_addr), .o_data_wr(o_wr), .ov_discard_mask(o_disc),
        .ov_dispatch_cnt(o_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr = 4'b0;
    endtask

    task automatic set_wr(input int p, input logic [8:0] b, input logic [2:0] t, input logic [4:0] a);
        bufid[p] = b;
        typ[p]   = t;
        addr[p]  = a;
        wr[p]    = 1'b1;
    endtask

    task automatic push_exp(input int p, input logic [8:0] b, input logic [2:0] t, input logic [4:0] a);
        q.push_back({4'(p), b, t, a});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk(name, 32'(q.size()), 0);
    endtask

    // Monitor: every o_data_wr must match the oldest expected descriptor and advance the count model.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = 16'd0;
        end else if (o_wr) begin
            if (q.size() == 0) begin
                chk("spurious_data_wr", 32'(o_wr), 0);
            end else begin
                e = q.pop_front();
                chk("descriptor", {11'b0, o_inport, o_bufid, o_type, o_addr}, {11'b0, e});
            end
            exp_cnt = exp_cnt + 16'd1;
            chk("dispatch_cnt", 32'(o_cnt), 32'(exp_cnt));
        end
    end

    initial begin
        wr = 4'b0;
        for (int i = 0; i < 4; i++) begin
            bufid[i] = '0;
            typ[i]   = '0;
            addr[i]  = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data_wr", 32'(o_wr), 0);
        chk("reset_bufid", 32'(o_bufid), 0);
        chk("reset_type", 32'(o_type), 0);
        chk("reset_inport", 32'(o_inport), 0);
        chk("reset_addr", 32'(o_addr), 0);
        chk("reset_discard", 32'(o_disc), 0);
        chk("reset_cnt", 32'(o_cnt), 0);
        chk("reset_ready", 32'(rdy), 32'hF);
        rst = 1'b0;
        en  = 1'b1;

        // Single write on p2: latency and content
        set_wr(2, 9'h05A, 3'd4, 5'd7);
        push_exp(2, 9'h05A, 3'd4, 5'd7);
        tick();
        chk("lat_cycle_t1", 32'(o_wr), 0);
        tick();
        chk("lat_cycle_t2", 32'(o_wr), 1);
        chk("single_bufid", 32'(o_bufid), 32'h05A);
        chk("single_inport", 32'(o_inport), 2);
        chk("single_cnt", 32'(o_cnt), 1);
        drain("single_drain");

        // All four ports at once from rr_ptr=0
        do_reset();
        for (int p = 0; p < 4; p++) begin
            set_wr(p, 9'h100 + 9'(p), 3'(p), 5'(p + 1));
            push_exp(p, 9'h100 + 9'(p), 3'(p), 5'(p + 1));
        end
        tick();
        chk("rr_first_gap", 32'(o_wr), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_consecutive", 32'(o_wr), 1);
            chk("rr_order", 32'(o_inport), 32'(k));
        end
        drain("rr_drain");

        // Fill p1 with dispatch disabled, overflow once, then release
        do_reset();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_wr(1, 9'h020 + 9'(k), 3'd6, 5'(k));
            if (k < 4) push_exp(1, 9'h020 + 9'(k), 3'd6, 5'(k));
            tick();
            if (k < 3)  chk("fill_ready_hi", 32'(rdy[1]), 1);
            if (k == 3) chk("full_ready_lo", 32'(rdy[1]), 0);
            if (k < 4)  chk("fill_no_discard", 32'(o_disc), 0);
            if (k == 4) chk("overflow_discard", 32'(o_disc), 32'b0010);
        end
        tick();
        chk("discard_one_cycle", 32'(o_disc), 0);
        chk("disabled_no_output", 32'(o_wr), 0);
        en = 1'b1;
        drain("fill_drain");

        // Head-type priority: p0 non-TS vs p3 TS
        do_reset();
        en = 1'b0;
        set_wr(0, 9'h0A0, 3'd5, 5'd1);
        set_wr(3, 9'h0B3, 3'd0, 5'd2);
        tick();
`ifdef HDD_TS_PRIORITY_EN
        push_exp(3, 9'h0B3, 3'd0, 5'd2);
        push_exp(0, 9'h0A0, 3'd5, 5'd1);
`else
        push_exp(0, 9'h0A0, 3'd5, 5'd1);
        push_exp(3, 9'h0B3, 3'd0, 5'd2);
`endif
        en = 1'b1;
        drain("prio_drain");

        // Reset while three descriptors are queued
        en = 1'b0;
        set_wr(0, 9'h011, 3'd1, 5'd1);
        set_wr(1, 9'h022, 3'd2, 5'd2);
        set_wr(2, 9'h033, 3'd3, 5'd3);
        tick();
        do_reset();
        en = 1'b1;
        repeat (6) tick();
        chk("midreset_ready", 32'(rdy), 32'hF);
        chk("midreset_cnt", 32'(o_cnt), 0);
        chk("midreset_data_wr", 32'(o_wr), 0);

        // 65536 back-to-back dispatches on p0: counter wraps to 0
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            set_wr(0, 9'(i), 3'(i), 5'(i));
            push_exp(0, 9'(i), 3'(i), 5'(i));
            tick();
        end
        drain("wrap_drain");
        chk("wrap_cnt", 32'(o_cnt), 0);
        chk("wrap_no_discard", 32'(o_disc), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
